// File: rtl/regfile_debug_port_if.sv
// Debug-port bundle: control, register file port mux, dump stream out, load stream in.
// master is the host/register-file side, slave is the sequencer.
interface regfile_debug_port_if #(
   parameter int Nloc  = 32,
   parameter int Dbits = 32
);
   localparam int AW = $clog2(Nloc);

   logic             start;
   logic             mode;
   logic             busy;
   logic             done;
   logic [AW-1:0]    rf_ReadAddr;
   logic [Dbits-1:0] rf_ReadData;
   logic             rf_wr;
   logic [AW-1:0]    rf_WriteAddr;
   logic [Dbits-1:0] rf_WriteData;
   logic             out_valid;
   logic             out_ready;
   logic [AW-1:0]    out_addr;
   logic [Dbits-1:0] out_data;
   logic             in_valid;
   logic             in_ready;
   logic [Dbits-1:0] in_data;

   modport master (
      output start, mode, rf_ReadData, out_ready, in_valid, in_data,
      input  busy, done, rf_ReadAddr, rf_wr, rf_WriteAddr, rf_WriteData,
             out_valid, out_addr, out_data, in_ready
   );

   modport slave (
      input  start, mode, rf_ReadData, out_ready, in_valid, in_data,
      output busy, done, rf_ReadAddr, rf_wr, rf_WriteAddr, rf_WriteData,
             out_valid, out_addr, out_data, in_ready
   );
endinterface

// File: rtl/regfile_debug_port.sv
// Register file debug sequencer: dump streams all registers (first word 2 cycles after start),
// load writes registers 1..Nloc-1 one cycle after each accepted word; out_ready=0 stalls the walk.
module regfile_debug_port #(
   parameter int Nloc  = 32,
   parameter int Dbits = 32
) (
   input logic                 clock,
   input logic                 reset,
   regfile_debug_port_if.slave bus
);
   localparam int AW = $clog2(Nloc);
   localparam logic [AW-1:0] LAST_ADDR = AW'(Nloc - 1);
   localparam logic [AW-1:0] LAST_WORD = AW'(Nloc - 2);

   typedef enum logic [1:0] {IDLE, DUMP, LOAD, LOAD_END} state_t;

   state_t           state;
   logic [AW-1:0]    a;
   logic             cap_done;
   logic             busy_q;
   logic             done_q;
   logic             wr_q;
   logic [AW-1:0]    wr_addr_q;
   logic [Dbits-1:0] wr_data_q;
   logic             out_valid_q;
   logic [AW-1:0]    out_addr_q;
   logic [Dbits-1:0] out_data_q;
   logic             in_ready_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         a           <= '0;
         cap_done    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wr_q        <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         wr_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  busy_q     <= 1'b1;
                  a          <= '0;
                  cap_done   <= 1'b0;
                  in_ready_q <= bus.mode;
                  state      <= bus.mode ? LOAD : DUMP;
               end
            end
            DUMP: begin
               // cap_done means the held word is address Nloc-1, so its acceptance ends the dump
               if (out_valid_q && bus.out_ready && cap_done) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state       <= IDLE;
               end else if ((!out_valid_q || bus.out_ready) && !cap_done) begin
                  out_valid_q <= 1'b1;
                  out_addr_q  <= a;
                  out_data_q  <= bus.rf_ReadData;
                  if (a == LAST_ADDR) cap_done <= 1'b1;
                  else                a        <= a + 1'b1;
               end
            end
            LOAD: begin
               if (bus.in_valid) begin
                  wr_q      <= 1'b1;
                  wr_addr_q <= a + 1'b1;
                  wr_data_q <= bus.in_data;
                  if (a == LAST_WORD) begin
                     in_ready_q <= 1'b0;
                     state      <= LOAD_END;
                  end else begin
                     a <= a + 1'b1;
                  end
               end
            end
            LOAD_END: begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rf_ReadAddr  = (state == DUMP) ? a : '0;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.rf_wr        = wr_q;
   assign bus.rf_WriteAddr = wr_addr_q;
   assign bus.rf_WriteData = wr_data_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_addr     = out_addr_q;
   assign bus.out_data     = out_data_q;
   assign bus.in_ready     = in_ready_q;
endmodule

// File: tb/tb_regfile_debug_port.sv
// Directed bench for regfile_debug_port with a behavioural register file behind the port mux.
module tb_regfile_debug_port;
   logic clock;
   logic reset;
   logic preload;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   wr_cnt   = 0;
   logic wr0_seen = 1'b0;
   logic [31:0] mem    [32];
   logic [31:0] exp_rf [32];

   regfile_debug_port_if #(.Nloc(32), .Dbits(32)) bus ();

   regfile_debug_port #(.Nloc(32), .Dbits(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) begin
      if (preload) begin
         for (int k = 0; k < 32; k++) mem[k] <= 32'hA500_0000 + 32'(k);
      end else if (bus.rf_wr) begin
         mem[bus.rf_WriteAddr] <= bus.rf_WriteData;
         wr_cnt <= wr_cnt + 1;
         if (bus.rf_WriteAddr == 5'd0) wr0_seen <= 1'b1;
      end
   end

   assign bus.rf_ReadData = (bus.rf_ReadAddr == 5'd0) ? 32'h0 : mem[bus.rf_ReadAddr];

   task automatic test_reset();
      @(negedge clock);
      bus.start = 1'b1; bus.mode = 1'b0; bus.out_ready = 1'b0;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL reset_pre_busy: got %b want 1", bus.busy);
      end
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.rf_wr, bus.out_valid, bus.in_ready} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 00000",
                            {bus.busy, bus.done, bus.rf_wr, bus.out_valid, bus.in_ready});
      end
      n_checks++;
      if (bus.rf_ReadAddr !== 5'd0) begin
         n_fail++; $display("FAIL reset_readaddr: got %0d want 0", bus.rf_ReadAddr);
      end
      n_checks++;
      if ({bus.rf_WriteAddr, bus.out_addr} !== 10'd0) begin
         n_fail++; $display("FAIL reset_addrs: got %h want 0", {bus.rf_WriteAddr, bus.out_addr});
      end
      n_checks++;
      if ({bus.rf_WriteData, bus.out_data} !== 64'd0) begin
         n_fail++; $display("FAIL reset_data: got %h want 0", {bus.rf_WriteData, bus.out_data});
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_dump_full();
      @(negedge clock);
      bus.start = 1'b1; bus.mode = 1'b0; bus.out_ready = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      n_checks++;
      if ({bus.busy, bus.out_valid} !== 2'b10) begin
         n_fail++; $display("FAIL dump_cycle1: got busy,valid=%b want 10", {bus.busy, bus.out_valid});
      end
      for (int k = 0; k < 32; k++) begin
         @(negedge clock);
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.out_addr !== k[4:0] || bus.out_data !== exp_rf[k[4:0]]) begin
            n_fail++;
            $display("FAIL dump_word cycle %0d: got v=%b a=%0d d=%h want v=1 a=%0d d=%h",
                     k + 2, bus.out_valid, bus.out_addr, bus.out_data, k, exp_rf[k[4:0]]);
         end
      end
      @(negedge clock);
      n_checks++;
      if ({bus.done, bus.busy, bus.out_valid} !== 3'b100) begin
         n_fail++; $display("FAIL dump_done34: got done,busy,valid=%b want 100",
                            {bus.done, bus.busy, bus.out_valid});
      end
      @(negedge clock);
      n_checks++;
      if (bus.done !== 1'b0) begin
         n_fail++; $display("FAIL dump_done_pulse: got %b want 0", bus.done);
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_dump_backpressure();
      int          nexp = 0;
      logic        held = 1'b0;
      logic [4:0]  held_addr = '0;
      logic [31:0] held_data = '0;
      @(negedge clock);
      bus.start = 1'b1; bus.mode = 1'b0; bus.out_ready = 1'b0;
      for (int cyc = 1; cyc < 300 && nexp < 32; cyc++) begin
         @(negedge clock);
         bus.start = 1'b0;
         if (held) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_addr !== held_addr || bus.out_data !== held_data) begin
               n_fail++;
               $display("FAIL bp_stall_stable cycle %0d: got v=%b a=%0d d=%h want v=1 a=%0d d=%h",
                        cyc, bus.out_valid, bus.out_addr, bus.out_data, held_addr, held_data);
            end
         end
         bus.out_ready = (cyc % 3 == 2);
         held = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (bus.out_addr !== nexp[4:0] || bus.out_data !== exp_rf[nexp[4:0]]) begin
               n_fail++;
               $display("FAIL bp_word: got a=%0d d=%h want a=%0d d=%h",
                        bus.out_addr, bus.out_data, nexp, exp_rf[nexp[4:0]]);
            end
            nexp++;
         end else if (bus.out_valid) begin
            held = 1'b1; held_addr = bus.out_addr; held_data = bus.out_data;
         end
      end
      n_checks++;
      if (nexp != 32) begin
         n_fail++; $display("FAIL bp_word_count: got %0d want 32", nexp);
      end
      @(negedge clock);
      n_checks++;
      if ({bus.done, bus.out_valid} !== 2'b10) begin
         n_fail++; $display("FAIL bp_done: got done,valid=%b want 10", {bus.done, bus.out_valid});
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_load();
      int j = 0;
      int n = 0;
      logic pend = 1'b0;
      int   pend_j = 0;
      for (int k = 1; k < 32; k++) exp_rf[k] = 32'h100 + 32'(k - 1);
      @(negedge clock);
      bus.start = 1'b1; bus.mode = 1'b1; bus.in_valid = 1'b0;
      for (int cyc = 1; cyc < 200 && j < 31; cyc++) begin
         @(negedge clock);
         bus.start = 1'b0;
         n_checks++;
         if (pend && (bus.rf_wr !== 1'b1 || bus.rf_WriteAddr !== 5'(pend_j + 1)
                      || bus.rf_WriteData !== 32'h100 + 32'(pend_j))) begin
            n_fail++;
            $display("FAIL load_write cycle %0d: got wr=%b a=%0d d=%h want wr=1 a=%0d d=%h",
                     cyc, bus.rf_wr, bus.rf_WriteAddr, bus.rf_WriteData, pend_j + 1, 32'h100 + 32'(pend_j));
         end else if (!pend && bus.rf_wr !== 1'b0) begin
            n_fail++; $display("FAIL load_no_write cycle %0d: got wr=%b want 0", cyc, bus.rf_wr);
         end
         n_checks++;
         if ({bus.busy, bus.in_ready, bus.rf_ReadAddr} !== {2'b11, 5'd0}) begin
            n_fail++; $display("FAIL load_active cycle %0d: got busy=%b rdy=%b ra=%0d want 1 1 0",
                               cyc, bus.busy, bus.in_ready, bus.rf_ReadAddr);
         end
         bus.in_valid = (cyc % 4 != 3);
         bus.in_data  = 32'h100 + 32'(j);
         pend   = bus.in_valid;
         pend_j = j;
         if (bus.in_valid) j++;
      end
      n_checks++;
      if (j != 31) begin
         n_fail++; $display("FAIL load_word_count: got %0d want 31", j);
      end
      @(negedge clock);
      bus.in_valid = 1'b0;
      n_checks++;
      if ({bus.in_ready, bus.rf_wr, bus.done} !== 3'b010 || bus.rf_WriteAddr !== 5'd31
          || bus.rf_WriteData !== 32'h11E) begin
         n_fail++; $display("FAIL load_last_write: got rdy,wr,done=%b a=%0d d=%h want 010 a=31 d=0000011e",
                            {bus.in_ready, bus.rf_wr, bus.done}, bus.rf_WriteAddr, bus.rf_WriteData);
      end
      @(negedge clock);
      n_checks++;
      if ({bus.done, bus.busy, bus.rf_wr} !== 3'b100 || mem[31] !== 32'h11E) begin
         n_fail++; $display("FAIL load_done: got done,busy,wr=%b r31=%h want 100 r31=0000011e",
                            {bus.done, bus.busy, bus.rf_wr}, mem[31]);
      end
      n_checks++;
      if (wr0_seen !== 1'b0) begin
         n_fail++; $display("FAIL load_addr0_write: got %b want 0", wr0_seen);
      end
      @(negedge clock);
      bus.start = 1'b1; bus.mode = 1'b0; bus.out_ready = 1'b1;
      for (int cyc = 1; cyc < 100 && n < 32; cyc++) begin
         @(negedge clock);
         bus.start = 1'b0;
         if (bus.out_valid) begin
            n_checks++;
            if (bus.out_addr !== n[4:0] || bus.out_data !== exp_rf[n[4:0]]) begin
               n_fail++; $display("FAIL load_readback: got a=%0d d=%h want a=%0d d=%h",
                                  bus.out_addr, bus.out_data, n, exp_rf[n[4:0]]);
            end
            n++;
         end
      end
      n_checks++;
      if (n != 32) begin
         n_fail++; $display("FAIL load_readback_count: got %0d want 32", n);
      end
      @(negedge clock);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_start_while_busy();
      int n = 0;
      int last_cyc = 0;
      @(negedge clock);
      bus.start = 1'b1; bus.mode = 1'b0; bus.out_ready = 1'b1;
      for (int cyc = 1; cyc < 60 && n < 32; cyc++) begin
         @(negedge clock);
         bus.start = (cyc == 5);
         bus.mode  = (cyc == 5);
         n_checks++;
         if (bus.in_ready !== 1'b0 || bus.rf_wr !== 1'b0) begin
            n_fail++; $display("FAIL busy_start_load_leak cycle %0d: got rdy=%b wr=%b want 0 0",
                               cyc, bus.in_ready, bus.rf_wr);
         end
         if (bus.out_valid) begin
            n_checks++;
            if (bus.out_addr !== n[4:0] || bus.out_data !== exp_rf[n[4:0]]) begin
               n_fail++; $display("FAIL busy_start_word: got a=%0d d=%h want a=%0d d=%h",
                                  bus.out_addr, bus.out_data, n, exp_rf[n[4:0]]);
            end
            n++;
            last_cyc = cyc;
         end
      end
      bus.start = 1'b0; bus.mode = 1'b0;
      n_checks++;
      if (last_cyc != 33 || n != 32) begin
         n_fail++; $display("FAIL busy_start_timing: got last cycle %0d count %0d want 33 32", last_cyc, n);
      end
      @(negedge clock);
      n_checks++;
      if ({bus.done, bus.busy} !== 2'b10) begin
         n_fail++; $display("FAIL busy_start_done: got done,busy=%b want 10", {bus.done, bus.busy});
      end
      @(negedge clock);
      n_checks++;
      if ({bus.busy, bus.in_ready} !== 2'b00) begin
         n_fail++; $display("FAIL busy_start_ignored: got busy,rdy=%b want 00", {bus.busy, bus.in_ready});
      end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      int j = 0;
      int n = 0;
      int cnt0;
      @(negedge clock);
      bus.start = 1'b1; bus.mode = 1'b1; bus.in_valid = 1'b0;
      for (int cyc = 1; cyc < 50 && j < 10; cyc++) begin
         @(negedge clock);
         bus.start = 1'b0;
         bus.in_valid = 1'b1;
         bus.in_data  = 32'h200 + 32'(j);
         j++;
      end
      @(negedge clock);
      bus.in_valid = 1'b0;
      cnt0 = wr_cnt;
      n_checks++;
      if (bus.rf_wr !== 1'b1 || bus.rf_WriteAddr !== 5'd10) begin
         n_fail++; $display("FAIL rml_pending: got wr=%b a=%0d want 1 10", bus.rf_wr, bus.rf_WriteAddr);
      end
      #1 reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.in_ready, bus.rf_wr, bus.busy} !== 3'b000) begin
         n_fail++; $display("FAIL rml_abort: got rdy,wr,busy=%b want 000", {bus.in_ready, bus.rf_wr, bus.busy});
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if (wr_cnt != cnt0) begin
         n_fail++; $display("FAIL rml_late_write: got %0d writes want %0d", wr_cnt, cnt0);
      end
      for (int k = 1; k < 10; k++) exp_rf[k] = 32'h200 + 32'(k - 1);
      for (int k = 1; k < 32; k++) begin
         n_checks++;
         if (mem[k[4:0]] !== exp_rf[k[4:0]]) begin
            n_fail++; $display("FAIL rml_contents reg %0d: got %h want %h", k, mem[k[4:0]], exp_rf[k[4:0]]);
         end
      end
      bus.start = 1'b1; bus.mode = 1'b0; bus.out_ready = 1'b1;
      for (int cyc = 1; cyc < 100 && n < 32; cyc++) begin
         @(negedge clock);
         bus.start = 1'b0;
         if (bus.out_valid) begin
            n_checks++;
            if (bus.out_addr !== n[4:0] || bus.out_data !== exp_rf[n[4:0]]) begin
               n_fail++; $display("FAIL rml_restart_word: got a=%0d d=%h want a=%0d d=%h",
                                  bus.out_addr, bus.out_data, n, exp_rf[n[4:0]]);
            end
            n++;
         end
      end
      @(negedge clock);
      n_checks++;
      if (n != 32 || bus.done !== 1'b1) begin
         n_fail++; $display("FAIL rml_restart_done: got count %0d done=%b want 32 1", n, bus.done);
      end
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; preload = 1'b0;
      bus.start = 1'b0; bus.mode = 1'b0; bus.out_ready = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0;
      repeat (2) @(negedge clock);
      preload = 1'b1;
      @(negedge clock);
      preload = 1'b0;
      reset = 1'b0;
      for (int k = 0; k < 32; k++) exp_rf[k] = (k == 0) ? 32'h0 : 32'hA500_0000 + 32'(k);
      @(negedge clock);
      test_reset();
      test_dump_full();
      test_dump_backpressure();
      test_load();
      test_start_while_busy();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
